// File: rtl/id_queue_decode.sv
// RV32I decode stage with an instruction queue in front of it.
// The head entry is decoded, forwarded and popped into a registered EX slot.
module id_queue_decode #(
  parameter int QUEUE_DEPTH = 4,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [31:0]     if_inst_i,
  output logic            if_ready_o,
  output logic [4:0]      reg1_addr_o,
  output logic [4:0]      reg2_addr_o,
  input  logic [XLEN-1:0] reg1_data_i,
  input  logic [XLEN-1:0] reg2_data_i,
  input  logic            ex_wreg_i,
  input  logic [4:0]      ex_wd_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            ex_is_load_i,
  input  logic            mem_wreg_i,
  input  logic [4:0]      mem_wd_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] reg1_o,
  output logic [XLEN-1:0] reg2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic            branch_enable_o,
  output logic [XLEN-1:0] branch_addr_o
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(QUEUE_DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ZERO   = '0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] pc_mem_q   [QUEUE_DEPTH];
  logic [XLEN-1:0] pc_mem_d   [QUEUE_DEPTH];
  logic [31:0]     inst_mem_q [QUEUE_DEPTH];
  logic [31:0]     inst_mem_d [QUEUE_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d;
  logic [XLEN-1:0] reg1_q, reg1_d;
  logic [XLEN-1:0] reg2_q, reg2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      wd_q, wd_d;
  logic            wreg_q, wreg_d;

  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;
  logic [6:0]      head_opc;
  logic [4:0]      head_rs1, head_rs2, head_rd;

  logic            dec_known, use_rs1, use_rs2, dec_writes, is_jal;
  logic [XLEN-1:0] dec_imm, op1, op2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;

  logic load_use, slot_free, pop, jal_taken, push;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign head_valid = (count_q != CNT_ZERO);
  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_inst  = inst_mem_q[rd_ptr_q];
  assign head_opc   = head_inst[6:0];
  assign head_rs1   = head_inst[19:15];
  assign head_rs2   = head_inst[24:20];
  assign head_rd    = head_inst[11:7];

  assign imm_i    = sext({{20{head_inst[31]}}, head_inst[31:20]});
  assign imm_s    = sext({{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]});
  assign imm_b    = sext({{19{head_inst[31]}}, head_inst[31], head_inst[7],
                          head_inst[30:25], head_inst[11:8], 1'b0});
  assign imm_u    = sext({head_inst[31:12], 12'b0});
  assign imm_j    = sext({{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                          head_inst[20], head_inst[30:21], 1'b0});
  assign pc_plus4 = head_pc + XLEN'(4);

  // Format classification: which operands are read, whether rd is written, which immediate.
  always_comb begin
    dec_known  = 1'b1;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    dec_writes = 1'b0;
    is_jal     = 1'b0;
    dec_imm    = '0;
    case (head_opc)
      OPC_LUI:    begin dec_writes = 1'b1; dec_imm = imm_u; end
      OPC_AUIPC:  begin dec_writes = 1'b1; dec_imm = imm_u + head_pc; end
      OPC_JAL:    begin dec_writes = 1'b1; is_jal = 1'b1; dec_imm = pc_plus4; end
      OPC_JALR:   begin use_rs1 = 1'b1; dec_writes = 1'b1; dec_imm = pc_plus4; end
      OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_b; end
      OPC_LOAD:   begin use_rs1 = 1'b1; dec_writes = 1'b1; dec_imm = imm_i; end
      OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_s; end
      OPC_OPIMM:  begin use_rs1 = 1'b1; dec_writes = 1'b1; dec_imm = imm_i; end
      OPC_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_writes = 1'b1; end
      OPC_FENCE:  dec_imm = imm_i;
      OPC_SYSTEM: dec_imm = imm_i;
      default:    dec_known = 1'b0;
    endcase
  end

  // Operand bypass: the youngest producer (EX) wins over MEM, x0 always reads zero.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (use_rs1 && head_rs1 != 5'd0) begin
      if (ex_wreg_i && ex_wd_i == head_rs1)        op1 = ex_wdata_i;
      else if (mem_wreg_i && mem_wd_i == head_rs1) op1 = mem_wdata_i;
      else                                         op1 = reg1_data_i;
    end
    if (use_rs2 && head_rs2 != 5'd0) begin
      if (ex_wreg_i && ex_wd_i == head_rs2)        op2 = ex_wdata_i;
      else if (mem_wreg_i && mem_wd_i == head_rs2) op2 = mem_wdata_i;
      else                                         op2 = reg2_data_i;
    end
  end

  assign load_use  = head_valid && dec_known && ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                     ((use_rs1 && head_rs1 == ex_wd_i) || (use_rs2 && head_rs2 == ex_wd_i));
  assign slot_free = !id_valid_q || ex_ready_i;
  assign pop       = head_valid && slot_free && !load_use && !flush_i;
  assign jal_taken = pop && dec_known && is_jal;
  assign push      = if_valid_i && if_ready_o && !flush_i && !jal_taken;

  // A flush or a taken JAL empties the queue outright, dropping any same-cycle push.
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush_i || jal_taken) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = if_pc_i;
        inst_mem_d[wr_ptr_q] = if_inst_i;
        wr_ptr_d             = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  // Output slot: holds while EX stalls it, otherwise takes the head or a zeroed bubble.
  always_comb begin
    id_valid_d = id_valid_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    funct7_d   = funct7_q;
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    imm_d      = imm_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    if (flush_i || slot_free) begin
      id_valid_d = 1'b0;
      pc_d       = '0;
      opcode_d   = '0;
      funct3_d   = '0;
      funct7_d   = '0;
      reg1_d     = '0;
      reg2_d     = '0;
      imm_d      = '0;
      wd_d       = '0;
      wreg_d     = 1'b0;
      if (pop) begin
        id_valid_d = 1'b1;
        pc_d       = head_pc;
        if (dec_known) begin
          opcode_d = head_opc;
          funct3_d = head_inst[14:12];
          funct7_d = head_inst[31:25];
          reg1_d   = op1;
          reg2_d   = op2;
          imm_d    = dec_imm;
          wd_d     = dec_writes ? head_rd : 5'd0;
          wreg_d   = dec_writes && (head_rd != 5'd0);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      pc_q       <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      imm_q      <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
    end else begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      imm_q      <= imm_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
    end
  end

  assign if_ready_o      = (count_q != FULL_COUNT);
  assign reg1_addr_o     = head_valid ? head_rs1 : 5'd0;
  assign reg2_addr_o     = head_valid ? head_rs2 : 5'd0;
  assign branch_enable_o = jal_taken;
  assign branch_addr_o   = jal_taken ? (head_pc + imm_j) : '0;

  assign id_valid_o = id_valid_q;
  assign pc_o       = pc_q;
  assign opcode_o   = opcode_q;
  assign funct3_o   = funct3_q;
  assign funct7_o   = funct7_q;
  assign reg1_o     = reg1_q;
  assign reg2_o     = reg2_q;
  assign imm_o      = imm_q;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q;

endmodule

// File: tb/tb_id_queue_decode.sv
// Directed bench for id_queue_decode: expected slot contents are queued on push
// and compared when EX accepts the slot.
module tb_id_queue_decode;

  logic        clk;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic [31:0] if_inst_i;
  logic        if_ready_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        ex_is_load_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        flush_i;
  logic        ex_ready_i;
  logic        id_valid_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] reg1_o, reg2_o, imm_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic        branch_enable_o;
  logic [31:0] branch_addr_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] opcode;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [31:0] wd;
    logic [31:0] wreg;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  id_queue_decode #(.QUEUE_DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .if_ready_o(if_ready_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .id_valid_o(id_valid_o), .pc_o(pc_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o),
    .wd_o(wd_o), .wreg_o(wreg_o),
    .branch_enable_o(branch_enable_o), .branch_addr_o(branch_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: every register xN holds 0x1000_0000 + N.
  assign reg1_data_i = 32'h1000_0000 + 32'(reg1_addr_o);
  assign reg2_data_i = 32'h1000_0000 + 32'(reg2_addr_o);

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] pc, input logic [31:0] opc,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  input logic [31:0] imm, input logic [31:0] wd,
                                  input logic [31:0] wreg);
    exp_t e;
    e.pc = pc; e.opcode = opc; e.reg1 = r1; e.reg2 = r2;
    e.imm = imm; e.wd = wd; e.wreg = wreg;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offers one entry and waits (bounded) until the queue takes it.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst,
                               input bit track, input exp_t e);
    bit accepted;
    bit done;
    done = 1'b0;
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      accepted = if_ready_o;
      @(posedge clk);
      #1;
      if (accepted) done = 1'b1;
    end
    if_valid_i = 1'b0;
    checkOutput("push_accepted", {31'b0, done}, 32'd1);
    if (done && track) sb.push_back(e);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput(tag, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Compares the slot against the oldest expectation whenever EX takes it.
  always @(negedge clk) begin
    if (!rst && id_valid_o && ex_ready_i) begin
      checkOutput("retire_expected", {31'b0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("slot_pc", pc_o, e.pc);
        checkOutput("slot_opcode", {25'b0, opcode_o}, e.opcode);
        checkOutput("slot_reg1", reg1_o, e.reg1);
        checkOutput("slot_reg2", reg2_o, e.reg2);
        checkOutput("slot_imm", imm_o, e.imm);
        checkOutput("slot_wd", {27'b0, wd_o}, e.wd);
        checkOutput("slot_wreg", {31'b0, wreg_o}, e.wreg);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    exp_t none;
    none = mk_exp(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; if_valid_i = 1'b0; if_pc_i = '0; if_inst_i = '0;
    ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
    flush_i = 1'b0; ex_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
    checkOutput("rst_if_ready", {31'b0, if_ready_o}, 32'd1);
    checkOutput("rst_pc", pc_o, 32'd0);
    checkOutput("rst_imm", imm_o, 32'd0);
    checkOutput("rst_branch_en", {31'b0, branch_enable_o}, 32'd0);
    checkOutput("rst_branch_addr", branch_addr_o, 32'd0);

    // Fill: one ADDI lands in the empty slot, four more fill the queue.
    for (int k = 1; k <= 5; k++)
      applyStimulus(32'((k - 1) * 4), enc_i(12'(k), 5'd0, 3'd0, 5'(k), 7'h13), 1'b1,
                    mk_exp(32'((k - 1) * 4), 32'h13, 0, 0, 32'(k), 32'(k), 1));
    checkOutput("full_if_ready", {31'b0, if_ready_o}, 32'd0);
    if_valid_i = 1'b1; if_pc_i = 32'h14; if_inst_i = enc_i(12'd6, 5'd0, 3'd0, 5'd6, 7'h13);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full_still_blocked", {31'b0, if_ready_o}, 32'd0);
    checkOutput("full_slot_held_pc", pc_o, 32'h0);
    checkOutput("full_slot_held_valid", {31'b0, id_valid_o}, 32'd1);
    ex_ready_i = 1'b1;
    applyStimulus(32'h14, enc_i(12'd6, 5'd0, 3'd0, 5'd6, 7'h13), 1'b1,
                  mk_exp(32'h14, 32'h13, 0, 0, 32'd6, 32'd6, 1));
    waitDrain("full_drain");

    // Load-use: lw x5 in EX, head is add x6,x5,x7.
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd5; ex_wdata_i = 32'hDEAD;
    applyStimulus(32'h40, enc_r(7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'h33), 1'b1,
                  mk_exp(32'h40, 32'h33, 32'h55AA, 32'h1000_0007, 0, 32'd6, 1));
    @(posedge clk);
    #1;
    checkOutput("lu_bubble", {31'b0, id_valid_o}, 32'd0);
    ex_is_load_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd5; mem_wdata_i = 32'h55AA;
    @(posedge clk);
    #1;
    checkOutput("lu_issue", {31'b0, id_valid_o}, 32'd1);
    waitDrain("lu_drain");
    mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;

    // Forwarding priority, then x0 is never forwarded.
    ex_wreg_i = 1'b1; ex_wd_i = 5'd3; ex_wdata_i = 32'h1111;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 32'h2222;
    applyStimulus(32'h80, enc_i(12'd5, 5'd3, 3'd0, 5'd8, 7'h13), 1'b1,
                  mk_exp(32'h80, 32'h13, 32'h1111, 0, 32'd5, 32'd8, 1));
    waitDrain("fwd_drain");
    ex_wd_i = 5'd0; mem_wd_i = 5'd0;
    applyStimulus(32'h84, enc_i(12'd7, 5'd0, 3'd0, 5'd9, 7'h13), 1'b1,
                  mk_exp(32'h84, 32'h13, 0, 0, 32'd7, 32'd9, 1));
    waitDrain("fwd_x0_drain");
    ex_wreg_i = 1'b0; ex_wdata_i = 32'h0; mem_wreg_i = 1'b0; mem_wdata_i = 32'h0;

    // S, U (AUIPC) and B immediates with regfile operands.
    applyStimulus(32'h500, 32'hFE20_AE23, 1'b1,
                  mk_exp(32'h500, 32'h23, 32'h1000_0001, 32'h1000_0002, 32'hFFFF_FFFC, 0, 0));
    applyStimulus(32'h504, 32'h1234_5397, 1'b1,
                  mk_exp(32'h504, 32'h17, 0, 0, 32'h1234_5504, 32'd7, 1));
    applyStimulus(32'h508, 32'hFE20_8CE3, 1'b1,
                  mk_exp(32'h508, 32'h63, 32'h1000_0001, 32'h1000_0002, 32'hFFFF_FFF8, 0, 0));
    waitDrain("imm_drain");

    // JAL at 0x100 (+0x20) behind a blocker, with younger entries and a same-cycle push.
    ex_ready_i = 1'b0;
    applyStimulus(32'hFC, enc_i(12'd10, 5'd0, 3'd0, 5'd10, 7'h13), 1'b1,
                  mk_exp(32'hFC, 32'h13, 0, 0, 32'd10, 32'd10, 1));
    applyStimulus(32'h100, 32'h0200_00EF, 1'b1,
                  mk_exp(32'h100, 32'h6F, 0, 0, 32'h104, 32'd1, 1));
    applyStimulus(32'h104, enc_i(12'd11, 5'd0, 3'd0, 5'd11, 7'h13), 1'b0, none);
    applyStimulus(32'h108, enc_i(12'd12, 5'd0, 3'd0, 5'd12, 7'h13), 1'b0, none);
    ex_ready_i = 1'b1;
    if_valid_i = 1'b1; if_pc_i = 32'h10C; if_inst_i = enc_i(12'd13, 5'd0, 3'd0, 5'd13, 7'h13);
    #1;
    checkOutput("jal_branch_en", {31'b0, branch_enable_o}, 32'd1);
    checkOutput("jal_branch_addr", branch_addr_o, 32'h120);
    @(posedge clk);
    #1;
    if_valid_i = 1'b0;
    #1;
    checkOutput("jal_pulse_once", {31'b0, branch_enable_o}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("jal_younger_gone", {31'b0, id_valid_o}, 32'd0);
    checkOutput("jal_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with a blocked slot, three queued entries and a same-cycle push.
    ex_ready_i = 1'b0;
    for (int k = 0; k < 4; k++)
      applyStimulus(32'h200 + 32'(k * 4), enc_i(12'(k), 5'd0, 3'd0, 5'd1, 7'h13), 1'b0, none);
    flush_i = 1'b1;
    if_valid_i = 1'b1; if_pc_i = 32'h210; if_inst_i = enc_i(12'd9, 5'd0, 3'd0, 5'd1, 7'h13);
    @(posedge clk);
    #1;
    flush_i = 1'b0; if_valid_i = 1'b0;
    checkOutput("flush_id_valid", {31'b0, id_valid_o}, 32'd0);
    checkOutput("flush_if_ready", {31'b0, if_ready_o}, 32'd1);
    ex_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush_queue_empty", {31'b0, id_valid_o}, 32'd0);

    // Unknown opcode becomes a valid NOP.
    ex_ready_i = 1'b0;
    applyStimulus(32'h300, 32'hFFFF_FFFF, 1'b0, none);
    @(posedge clk);
    #1;
    checkOutput("unk_valid", {31'b0, id_valid_o}, 32'd1);
    checkOutput("unk_opcode", {25'b0, opcode_o}, 32'd0);
    checkOutput("unk_wreg", {31'b0, wreg_o}, 32'd0);
    checkOutput("unk_pc", pc_o, 32'h300);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;

    // Asynchronous reset mid-stream, checked before any clock edge.
    applyStimulus(32'h400, enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13), 1'b0, none);
    applyStimulus(32'h404, enc_i(12'd2, 5'd0, 3'd0, 5'd2, 7'h13), 1'b0, none);
    checkOutput("pre_rst_valid", {31'b0, id_valid_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_id_valid", {31'b0, id_valid_o}, 32'd0);
    checkOutput("arst_pc", pc_o, 32'd0);
    checkOutput("arst_imm", imm_o, 32'd0);
    checkOutput("arst_wreg", {31'b0, wreg_o}, 32'd0);
    checkOutput("arst_if_ready", {31'b0, if_ready_o}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    ex_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_empty", {31'b0, id_valid_o}, 32'd0);
    checkOutput("post_rst_sb", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
